// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Two-master arbiter in front of a single-port RAM. The CPU FSM and a
// debug/loader port each raise a request; the arbiter grants one of them,
// runs a fixed-length RAM access of WAIT_STATES cycles, then pulses that
// requester's ready/ack for one cycle.
//
// Handshake (both ports): the requester raises cpu_cs / dbg_req together with
// stable we/addr/wdata and holds it until it sees its one-cycle
// cpu_ready / dbg_ack. Command fields are latched at grant, so anything the
// requester changes during ACCESS or DONE has no effect on the transfer in
// flight. A request still high in the IDLE cycle after DONE is a new transfer.
//
// Optional feature: define MEM_ARB_RR_EN to break simultaneous requests
// round-robin (CPU first after reset). Without it the CPU always wins a tie.
//
// Ports
//   CLK, RST            clock, asynchronous active-high reset
//   cpu_cs/we/addr/wdata CPU request, cpu_ready / cpu_rdata completion + data
//   dbg_req/we/addr/wdata debug request, dbg_ack / dbg_rdata completion + data
//   ram_cs/we/addr/wdata RAM command (zero outside ACCESS), ram_rdata return
//   dbg_fsm_state        current FSM state (IDLE=0, ACCESS=1, DONE=2)
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [15:0] cpu_rdata,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [15:0] dbg_wdata,
    output logic        dbg_ack,
    output logic [15:0] dbg_rdata,
    output logic        ram_cs,
    output logic        ram_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    input  logic [15:0] ram_rdata,
    output logic [1:0]  dbg_fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic       OWNER_CPU = 1'b0;
    localparam logic       OWNER_DBG = 1'b1;
    // Counter value on the final ACCESS cycle.
    localparam logic [3:0] LAST_CNT  = 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] cpu_rdata_q, cpu_rdata_d;
    logic [15:0] dbg_rdata_q, dbg_rdata_d;
    logic        grant_dbg;
    logic        in_access;

`ifdef MEM_ARB_RR_EN
    // Remembers who won the previous grant; reset to DBG so the CPU takes the
    // first tie after reset.
    logic        last_grant_q, last_grant_d;

    always_comb begin
        grant_dbg = dbg_req && !cpu_cs;
        if (cpu_cs && dbg_req) begin
            grant_dbg = (last_grant_q == OWNER_CPU);
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (cpu_cs || dbg_req)) begin
            last_grant_d = grant_dbg;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant_q <= OWNER_DBG;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`else
    // Fixed priority: debug only wins when the CPU is not asking.
    always_comb begin
        grant_dbg = dbg_req && !cpu_cs;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;

        case (state_q)
            IDLE: begin
                if (cpu_cs || dbg_req) begin
                    state_d = ACCESS;
                    cnt_d   = 4'd0;
                    owner_d = grant_dbg;
                    we_d    = grant_dbg ? dbg_we    : cpu_we;
                    addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
                    wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
                end
            end
            ACCESS: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    // RAM data is valid on the last ACCESS cycle; only reads
                    // update the owner's data register.
                    if (!we_q) begin
                        if (owner_q == OWNER_DBG) begin
                            dbg_rdata_d = ram_rdata;
                        end else begin
                            cpu_rdata_d = ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= OWNER_CPU;
            we_q        <= 1'b0;
            addr_q      <= 16'd0;
            wdata_q     <= 16'd0;
            cpu_rdata_q <= 16'd0;
            dbg_rdata_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    // RAM command is decoded from the state register so that an asynchronous
    // reset drops it immediately.
    assign in_access     = (state_q == ACCESS);
    assign ram_cs        = in_access;
    assign ram_we        = in_access && we_q;
    assign ram_addr      = in_access ? addr_q  : 16'd0;
    assign ram_wdata     = in_access ? wdata_q : 16'd0;

    // Single owner bit makes ready and ack mutually exclusive.
    assign cpu_ready     = (state_q == DONE) && (owner_q == OWNER_CPU);
    assign dbg_ack       = (state_q == DONE) && (owner_q == OWNER_DBG);
    assign cpu_rdata     = cpu_rdata_q;
    assign dbg_rdata     = dbg_rdata_q;
    assign dbg_fsm_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: main instance at WAIT_STATES=2 with a
// RAM model, plus WAIT_STATES=1 and 15 instances for latency extremes.
module tb_mem_arbiter;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- main DUT (WAIT_STATES = 2) ----------------
    logic        cpu_cs = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
    logic [15:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
    logic        cpu_ready, dbg_ack, ram_cs, ram_we;
    logic [15:0] cpu_rdata, dbg_rdata, ram_addr, ram_wdata, ram_rdata;
    logic [1:0]  fsm_state;

    mem_arbiter #(.WAIT_STATES(2)) u_dut (
        .CLK(CLK), .RST(RST),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .dbg_fsm_state(fsm_state)
    );

    // RAM model: synchronous write, combinational read; 0x3000 preloaded.
    logic [15:0] mem [0:65535];
    bit          mem_loaded = 1'b0;
    always @(posedge CLK) begin
        if (!mem_loaded) begin
            mem[16'h3000] <= 16'h1234;
            mem_loaded    <= 1'b1;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
    end
    assign ram_rdata = mem[ram_addr];

    // ---------------- WAIT_STATES = 1 and 15 instances ----------------
    logic        w1_cs = 0, w15_cs = 0;
    logic        w1_ready, w1_ack, w1_ram_cs, w1_ram_we;
    logic        w15_ready, w15_ack, w15_ram_cs, w15_ram_we;
    logic [15:0] w1_rdata, w1_drdata, w1_ram_addr, w1_ram_wdata;
    logic [15:0] w15_rdata, w15_drdata, w15_ram_addr, w15_ram_wdata;
    logic [1:0]  w1_state, w15_state;
    logic [15:0] w_addr = 16'h0100;

    mem_arbiter #(.WAIT_STATES(1)) u_dut_w1 (
        .CLK(CLK), .RST(RST),
        .cpu_cs(w1_cs), .cpu_we(1'b0), .cpu_addr(w_addr), .cpu_wdata(16'h0000),
        .cpu_ready(w1_ready), .cpu_rdata(w1_rdata),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_ack(w1_ack), .dbg_rdata(w1_drdata),
        .ram_cs(w1_ram_cs), .ram_we(w1_ram_we), .ram_addr(w1_ram_addr), .ram_wdata(w1_ram_wdata),
        .ram_rdata(w1_ram_addr ^ 16'h5A5A), .dbg_fsm_state(w1_state)
    );

    mem_arbiter #(.WAIT_STATES(15)) u_dut_w15 (
        .CLK(CLK), .RST(RST),
        .cpu_cs(w15_cs), .cpu_we(1'b0), .cpu_addr(w_addr), .cpu_wdata(16'h0000),
        .cpu_ready(w15_ready), .cpu_rdata(w15_rdata),
        .dbg_req(1'b0), .dbg_we(1'b0), .dbg_addr(16'h0000), .dbg_wdata(16'h0000),
        .dbg_ack(w15_ack), .dbg_rdata(w15_drdata),
        .ram_cs(w15_ram_cs), .ram_we(w15_ram_we), .ram_addr(w15_ram_addr), .ram_wdata(w15_ram_wdata),
        .ram_rdata(w15_ram_addr ^ 16'h5A5A), .dbg_fsm_state(w15_state)
    );

    // ---------------- driver ----------------
    // Called at a negedge with the DUT idle. Runs one transfer on the main
    // instance, drops the request on completion and returns at the negedge of
    // the following IDLE cycle. lat = negedges from request to ready/ack
    // (-1 if it never came).
    task automatic run_xfer(input bit is_dbg, input bit we, input logic [15:0] addr,
                            input logic [15:0] wdata, output int lat, output int cs_cycles,
                            output int other, output logic [15:0] seen_addr,
                            output logic [15:0] seen_wdata, output logic seen_we);
        lat = -1; cs_cycles = 0; other = 0;
        seen_addr = 16'h0; seen_wdata = 16'h0; seen_we = 1'b0;
        if (is_dbg) begin
            dbg_req = 1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
        end else begin
            cpu_cs = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (ram_cs) begin
                cs_cycles++; seen_addr = ram_addr; seen_wdata = ram_wdata; seen_we = ram_we;
            end
            if (is_dbg ? cpu_ready : dbg_ack) other++;
            if (is_dbg ? dbg_ack : cpu_ready) begin
                lat = k;
                break;
            end
        end
        cpu_cs = 0; dbg_req = 0;
        @(negedge CLK);
        if (cpu_ready || dbg_ack) other++;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RST = 1; cpu_cs = 1;
        repeat (3) @(negedge CLK);
        n_checks++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL reset_ram_cs: got %b want 0", ram_cs); end
        n_checks++; if ({ram_we, cpu_ready, dbg_ack} !== 3'b000) begin n_fail++; $display("FAIL reset_strobes: got %b want 000", {ram_we, cpu_ready, dbg_ack}); end
        n_checks++; if ({ram_addr, ram_wdata} !== 32'h0) begin n_fail++; $display("FAIL reset_ram_bus: got %h want 0", {ram_addr, ram_wdata}); end
        n_checks++; if ({cpu_rdata, dbg_rdata} !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {cpu_rdata, dbg_rdata}); end
        n_checks++; if (fsm_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        cpu_cs = 0;
        RST = 0;
        @(negedge CLK);
    endtask

    task automatic test_cpu_read;
        bit exp_cs, exp_rdy;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h3000;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            exp_cs  = (k == 1 || k == 2);
            exp_rdy = (k == 3);
            n_checks++; if (ram_cs !== exp_cs) begin n_fail++; $display("FAIL read_ram_cs c%0d: got %b want %b", k, ram_cs, exp_cs); end
            n_checks++; if (cpu_ready !== exp_rdy) begin n_fail++; $display("FAIL read_ready c%0d: got %b want %b", k, cpu_ready, exp_rdy); end
            if (exp_cs) begin
                n_checks++; if (ram_addr !== 16'h3000) begin n_fail++; $display("FAIL read_ram_addr c%0d: got %h want 3000", k, ram_addr); end
            end
            if (k >= 3) cpu_cs = 0;
        end
        n_checks++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL read_rdata: got %h want 1234", cpu_rdata); end
    endtask

    task automatic test_write_then_dbg_read;
        int lat, csn, other;
        logic [15:0] sa, sw;
        logic swe;
        run_xfer(0, 1, 16'h0005, 16'hBEEF, lat, csn, other, sa, sw, swe);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", lat); end
        n_checks++; if (csn !== 2) begin n_fail++; $display("FAIL write_cs_cycles: got %0d want 2", csn); end
        n_checks++; if ({swe, sa, sw} !== {1'b1, 16'h0005, 16'hBEEF}) begin n_fail++; $display("FAIL write_ram_cmd: got %h want 10005beef", {swe, sa, sw}); end
        n_checks++; if (other !== 0) begin n_fail++; $display("FAIL write_stray_pulse: got %0d want 0", other); end
        n_checks++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL write_keeps_rdata: got %h want 1234", cpu_rdata); end
        run_xfer(1, 0, 16'h0005, 16'h0000, lat, csn, other, sa, sw, swe);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL dbg_read_latency: got %0d want 3", lat); end
        n_checks++; if (dbg_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL dbg_read_rdata: got %h want beef", dbg_rdata); end
        n_checks++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL dbg_read_cpu_rdata: got %h want 1234", cpu_rdata); end
        n_checks++; if (other !== 0) begin n_fail++; $display("FAIL dbg_read_stray_pulse: got %0d want 0", other); end
    endtask

    task automatic test_addr_hold;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h0010;
        @(negedge CLK);
        n_checks++; if (ram_addr !== 16'h0010) begin n_fail++; $display("FAIL hold_addr c1: got %h want 0010", ram_addr); end
        cpu_addr = 16'h0020;
        @(negedge CLK);
        n_checks++; if (ram_addr !== 16'h0010) begin n_fail++; $display("FAIL hold_addr c2: got %h want 0010", ram_addr); end
        @(negedge CLK);
        n_checks++; if ({cpu_ready, ram_addr} !== {1'b1, 16'h0000}) begin n_fail++; $display("FAIL hold_done: got %h want 10000", {cpu_ready, ram_addr}); end
        cpu_cs = 0;
        @(negedge CLK);
    endtask

    // Both raise in the same IDLE cycle; each drops after its ack and comes
    // back two cycles later, so the loser of the first tie is served next.
    task automatic test_arbitration;
        int order[4] = '{-1, -1, -1, -1};
        int n = 0, both = 0, cpu_low = 0, dbg_low = 0;
        cpu_we = 0; cpu_addr = 16'h3000; dbg_we = 0; dbg_addr = 16'h0005;
        cpu_cs = 1; dbg_req = 1;
        for (int k = 1; k <= 80; k++) begin
            @(negedge CLK);
            if (cpu_ready && dbg_ack) both++;
            if (cpu_ready) begin
                order[n] = 0; n++; cpu_cs = 0; cpu_low = 2;
            end else if (cpu_low > 0) begin
                cpu_low--; if (cpu_low == 0) cpu_cs = 1;
            end
            if (dbg_ack) begin
                order[n] = 1; n++; dbg_req = 0; dbg_low = 2;
            end else if (dbg_low > 0) begin
                dbg_low--; if (dbg_low == 0) dbg_req = 1;
            end
            if (n >= 4) break;
        end
        cpu_cs = 0; dbg_req = 0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (order[i] !== i % 2) begin n_fail++; $display("FAIL arb_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
        end
        n_checks++; if (both !== 0) begin n_fail++; $display("FAIL arb_overlap: got %0d want 0", both); end
        n_checks++; if ({cpu_rdata, dbg_rdata} !== {16'h1234, 16'hBEEF}) begin n_fail++; $display("FAIL arb_rdata: got %h want 1234beef", {cpu_rdata, dbg_rdata}); end
    endtask

    // Both held high continuously right after reset; each completion is
    // followed immediately by the next grant (4 cycles apart).
    task automatic test_arb_continuous;
        int order[4] = '{-1, -1, -1, -1};
        int at[4] = '{0, 0, 0, 0};
        int exp_order[4];
        int n = 0;
`ifdef MEM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        RST = 1;
        @(negedge CLK);
        RST = 0;
        cpu_we = 0; cpu_addr = 16'h3000; dbg_we = 0; dbg_addr = 16'h0005;
        cpu_cs = 1; dbg_req = 1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (cpu_ready) begin order[n] = 0; at[n] = k; n++; end
            else if (dbg_ack) begin order[n] = 1; at[n] = k; n++; end
            if (n >= 4) break;
        end
        cpu_cs = 0; dbg_req = 0;
        @(negedge CLK);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (order[i] !== exp_order[i]) begin n_fail++; $display("FAIL cont_order[%0d]: got %0d want %0d", i, order[i], exp_order[i]); end
            n_checks++; if (at[i] !== 4 * i + 3) begin n_fail++; $display("FAIL cont_timing[%0d]: got %0d want %0d", i, at[i], 4 * i + 3); end
        end
    endtask

    task automatic test_reset_mid_access;
        int lat, csn, other, pulses = 0;
        logic [15:0] sa, sw;
        logic swe;
        cpu_cs = 1; cpu_we = 0; cpu_addr = 16'h3000;
        @(negedge CLK);
        n_checks++; if ({ram_cs, cpu_rdata} !== {1'b1, 16'h1234}) begin n_fail++; $display("FAIL rstmid_pre: got %h want 11234", {ram_cs, cpu_rdata}); end
        @(negedge CLK);
        RST = 1; cpu_cs = 0;
        #1;
        n_checks++; if (ram_cs !== 1'b0) begin n_fail++; $display("FAIL rstmid_ram_cs: got %b want 0", ram_cs); end
        n_checks++; if (cpu_rdata !== 16'h0000) begin n_fail++; $display("FAIL rstmid_rdata: got %h want 0000", cpu_rdata); end
        @(negedge CLK);
        RST = 0;
        repeat (3) begin
            @(negedge CLK);
            if (cpu_ready || dbg_ack) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL rstmid_no_ready: got %0d want 0", pulses); end
        run_xfer(0, 0, 16'h3000, 16'h0000, lat, csn, other, sa, sw, swe);
        n_checks++; if ({lat, csn} !== {32'd3, 32'd2}) begin n_fail++; $display("FAIL rstmid_fresh_xfer: got lat %0d cs %0d want 3 2", lat, csn); end
        n_checks++; if (cpu_rdata !== 16'h1234) begin n_fail++; $display("FAIL rstmid_fresh_rdata: got %h want 1234", cpu_rdata); end
    endtask

    // Back-to-back CPU reads with cs held high: completion k lands on
    // negedge (WS+2)*k + WS+1 from the request.
    task automatic test_wait_states;
        int a1[3] = '{0, 0, 0};
        int a15[3] = '{0, 0, 0};
        int n1 = 0, n15 = 0, extra = 0, cs1 = 0, cs15 = 0;
        w1_cs = 1; w15_cs = 1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge CLK);
            if (w1_ram_cs) cs1++;
            if (w15_ram_cs) cs15++;
            if (w1_ack || w15_ack) extra++;
            if (w1_ready) begin
                if (n1 < 3) a1[n1] = k; else extra++;
                n1++;
                if (n1 == 3) w1_cs = 0;
            end
            if (w15_ready) begin
                if (n15 < 3) a15[n15] = k; else extra++;
                n15++;
                if (n15 == 3) w15_cs = 0;
            end
        end
        w1_cs = 0; w15_cs = 0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (a1[i] !== 3 * i + 2) begin n_fail++; $display("FAIL ws1_ready[%0d]: got %0d want %0d", i, a1[i], 3 * i + 2); end
            n_checks++; if (a15[i] !== 17 * i + 16) begin n_fail++; $display("FAIL ws15_ready[%0d]: got %0d want %0d", i, a15[i], 17 * i + 16); end
        end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ws_spurious: got %0d want 0", extra); end
        n_checks++; if ({cs1, cs15} !== {32'd3, 32'd45}) begin n_fail++; $display("FAIL ws_cs_cycles: got %0d %0d want 3 45", cs1, cs15); end
        n_checks++; if ({w1_rdata, w15_rdata} !== {16'h5B5A, 16'h5B5A}) begin n_fail++; $display("FAIL ws_rdata: got %h want 5b5a5b5a", {w1_rdata, w15_rdata}); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_cpu_read();
        test_write_then_dbg_read();
        test_addr_hold();
        test_arbitration();
        test_arb_continuous();
        test_reset_mid_access();
        test_wait_states();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
